// File: rtl/audio_pkg.sv
// Shared audio types and helpers for the sample players, mixer and PWM stage.
// Holds the sample format, the offset-binary silence code and a 10-bit to 8-bit saturator.
package audio_pkg;
  localparam int SMPL_W = 8;
  localparam int NCH    = 4;

  typedef logic signed [SMPL_W-1:0] sample_t;

  localparam logic [7:0] DUTY_SILENCE = 8'h80;

  localparam logic signed [9:0] SAT_MAX = 10'sd127;
  localparam logic signed [9:0] SAT_MIN = -10'sd128;

  function automatic sample_t sat8(input logic signed [9:0] x);
    sample_t r;
    if (x > SAT_MAX)      r = sample_t'(8'h7F);
    else if (x < SAT_MIN) r = sample_t'(8'h80);
    else                  r = sample_t'(x[7:0]);
    return r;
  endfunction
endpackage

// File: rtl/mix_gain.sv
// Purpose: per-channel mute and arithmetic-shift attenuation (mixer stage 1).
// Latency: 1 cycle, captured only on in_valid; holds otherwise.
// Backpressure: none, accepts a sample on every in_valid.
module mix_gain
  import audio_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] smpl,
  input  logic       mute,
  input  logic [1:0] vol,
  output logic [7:0] gain
);

  sample_t shifted;

  // >>> on a signed operand rounds toward -inf, as the mixer expects.
  assign shifted = sample_t'(sample_t'(smpl) >>> vol);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain <= '0;
    end else if (in_valid) begin
      gain <= mute ? '0 : shifted;
    end
  end

endmodule

// File: rtl/sample_mixer.sv
// Purpose: four-channel gain, pair sum, saturating mix to offset-binary PWM duty, clip LED hold.
// Latency: 3 cycles from the in_valid capture edge to out_valid/duty.
// Backpressure: none; valids advance every cycle, full-rate in_valid is supported.
module sample_mixer
  import audio_pkg::*;
#(
  parameter int CLIP_HOLD = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] smpl_0,
  input  logic [7:0] smpl_1,
  input  logic [7:0] smpl_2,
  input  logic [7:0] smpl_3,
  input  logic [3:0] mute,
  input  logic [7:0] vol,
  output logic       out_valid,
  output logic [7:0] duty,
  output logic       clip
);

  localparam int CW = $clog2(CLIP_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(CLIP_HOLD);

  logic [7:0] smpl_a [NCH];
  logic [7:0] g      [NCH];

  assign smpl_a[0] = smpl_0;
  assign smpl_a[1] = smpl_1;
  assign smpl_a[2] = smpl_2;
  assign smpl_a[3] = smpl_3;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    mix_gain u_gain (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .smpl     (smpl_a[n]),
      .mute     (mute[n]),
      .vol      (vol[2*n +: 2]),
      .gain     (g[n])
    );
  end

  logic                v1, v2, v3;
  logic signed [8:0]   p0, p1;
  logic signed [9:0]   s;
  logic                clipped;
  logic [CW-1:0]       cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      p0 <= '0;
      p1 <= '0;
      s  <= '0;
    end else begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (v1) begin
        p0 <= {g[0][7], g[0]} + {g[1][7], g[1]};
        p1 <= {g[2][7], g[2]} + {g[3][7], g[3]};
      end
      if (v2) begin
        s <= {p0[8], p0} + {p1[8], p1};
      end
    end
  end

  assign clipped = (s > SAT_MAX) || (s < SAT_MIN);

  // Reload wins over decrement so a fresh clip always restarts the full hold.
  always_comb begin
    cnt_nxt = cnt;
    if (v3) begin
      if (clipped)        cnt_nxt = HOLD_LOAD;
      else if (cnt != '0) cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      duty      <= DUTY_SILENCE;
      cnt       <= '0;
      clip      <= 1'b0;
    end else begin
      out_valid <= v3;
      if (v3) begin
        duty <= sat8(s) ^ DUTY_SILENCE;
      end
      cnt  <= cnt_nxt;
      clip <= (cnt_nxt != '0);
    end
  end

endmodule

// File: tb/tb_sample_mixer.sv
// Directed table-driven bench for sample_mixer (CLIP_HOLD = 4) plus clip-hold and reset sequences.
module tb_sample_mixer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] smpl_0, smpl_1, smpl_2, smpl_3;
  logic [3:0] mute;
  logic [7:0] vol;
  logic       out_valid;
  logic [7:0] duty;
  logic       clip;

  always #5 clk = ~clk;

  sample_mixer #(.CLIP_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .smpl_0    (smpl_0),
    .smpl_1    (smpl_1),
    .smpl_2    (smpl_2),
    .smpl_3    (smpl_3),
    .mute      (mute),
    .vol       (vol),
    .out_valid (out_valid),
    .duty      (duty),
    .clip      (clip)
  );

  typedef struct {
    logic [7:0] s0, s1, s2, s3;
    logic [3:0] mute;
    logic [7:0] vol;
    logic [7:0] duty;
    logic       clip;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t tv  [10];
  vec_t seq [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    smpl_0 = v.s0; smpl_1 = v.s1; smpl_2 = v.s2; smpl_3 = v.s3;
    mute = v.mute; vol = v.vol;
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    smpl_0 = 8'($urandom); smpl_1 = 8'($urandom);
    smpl_2 = 8'($urandom); smpl_3 = 8'($urandom);
    mute = 4'($urandom); vol = 8'($urandom);
  endtask

  task automatic strobe(input vec_t v);
    drive(v);
    @(posedge clk); #1;
    scramble();
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Back-to-back strobes; sample i is expected after the edge of iteration i+3.
  task automatic run_seq(input string nm, input int n);
    for (int c = 0; c < n + 3; c++) begin
      if (c < n) drive(seq[c]);
      else       scramble();
      @(posedge clk); #1;
      if (c >= 3) begin
        check({nm, "_vld"},  32'(out_valid), 32'd1);
        check({nm, "_duty"}, 32'(duty), 32'(seq[c-3].duty));
        check({nm, "_clip"}, 32'(clip), 32'(seq[c-3].clip));
      end
    end
    scramble();
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic [7:0] a, b, c, d, input logic [3:0] m,
                              input logic [7:0] v, input logic [7:0] du, input logic cl);
    vec_t r;
    r.s0 = a; r.s1 = b; r.s2 = c; r.s3 = d;
    r.mute = m; r.vol = v; r.duty = du; r.clip = cl;
    return r;
  endfunction

  initial begin
    int   lat;
    vec_t z;

    tv[0] = mk(8'h10, 8'h10, 8'h10, 8'h10, 4'b0000, 8'h00, 8'hC0, 1'b0); // 64
    tv[1] = mk(8'hFD, 8'h55, 8'h66, 8'h77, 4'b1110, 8'h01, 8'h7E, 1'b0); // -3>>>1 = -2
    tv[2] = mk(8'h7F, 8'h55, 8'h66, 8'h77, 4'b1110, 8'h03, 8'h8F, 1'b0); // 127>>>3 = 15
    tv[3] = mk(8'h40, 8'h40, 8'hC0, 8'h20, 4'b0000, 8'h84, 8'hA8, 1'b0); // 64+32-64+8 = 40
    tv[4] = mk(8'hE0, 8'hE0, 8'hE0, 8'hE0, 4'b0000, 8'h00, 8'h00, 1'b0); // exactly -128
    tv[5] = mk(8'h7F, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 8'hFF, 1'b0); // exactly 127
    tv[6] = mk(8'h7F, 8'h7F, 8'h7F, 8'h7F, 4'b0000, 8'h00, 8'hFF, 1'b1); // 508
    tv[7] = mk(8'h80, 8'h80, 8'h80, 8'h80, 4'b0000, 8'h00, 8'h00, 1'b1); // -512
    tv[8] = mk(8'h40, 8'h40, 8'h11, 8'h22, 4'b1100, 8'h00, 8'hFF, 1'b1); // 128
    tv[9] = mk(8'h80, 8'hFF, 8'h33, 8'h44, 4'b1100, 8'h00, 8'h00, 1'b1); // -129
    z = mk(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h80, 1'b0);

    rst_n = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld",  32'(out_valid), 32'd0);
    check("rst_duty", 32'(duty), 32'h80);
    check("rst_clip", 32'(clip), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      strobe(tv[i]);
      wait_out(lat);
      check($sformatf("v%0d_lat", i),  32'(lat), 32'd3);
      check($sformatf("v%0d_duty", i), 32'(duty), 32'(tv[i].duty));
      check($sformatf("v%0d_clip", i), 32'(clip), 32'(tv[i].clip));
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d_hold_vld", i),  32'(out_valid), 32'd0);
      check($sformatf("v%0d_hold_duty", i), 32'(duty), 32'(tv[i].duty));
    end

    // One clip then four silent samples: lit through the 3rd, dark on the 4th.
    seq[0] = tv[6];
    for (int i = 1; i <= 4; i++) begin
      seq[i] = z;
      seq[i].clip = (i < 4);
    end
    run_seq("hold", 5);

    // A clip on the 3rd sample reloads the counter to the full hold.
    seq[0] = tv[6];
    seq[1] = z; seq[1].clip = 1'b1;
    seq[2] = z; seq[2].clip = 1'b1;
    seq[3] = tv[7];
    for (int i = 4; i < 8; i++) begin
      seq[i] = z;
      seq[i].clip = (i < 7);
    end
    run_seq("reload", 8);

    // Reset one cycle after a clipped strobe discards it.
    strobe(tv[6]);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    check("mid_rst_vld_cnt", 32'(lat), 32'd0);
    check("mid_rst_duty",    32'(duty), 32'h80);
    check("mid_rst_clip",    32'(clip), 32'd0);
    strobe(tv[0]);
    wait_out(lat);
    check("post_rst_lat",  32'(lat), 32'd3);
    check("post_rst_duty", 32'(duty), 32'hC0);
    check("post_rst_clip", 32'(clip), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
